// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 4-bit-opcode / 8-bit-fun datapath: FETCH, DECODE, EXEC, MEM, WB
// over one shared memory, halting on illegal encodings or memory timeouts.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [7:0] fun,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwen,
  output logic       ir_wen,
  output logic       pc_wen,
  output logic [1:0] pc_sel,
  output logic [2:0] resfun,
  output logic       selmem,
  output logic       selimm,
  output logic       seldata,
  output logic       wen,
  output logic       ldwnd,
  output logic       illegal,
  output logic       bus_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Memory handshake: mem_req stays high with address/write controls stable
  // until the first cycle mem_ready is high; that cycle completes the access.
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_LOAD = 4'd0, C_STORE = 4'd1, C_JUMP = 4'd2, C_BRANCH = 4'd3, C_MOVE = 4'd4,
    C_ALU = 4'd5, C_CMP = 4'd6, C_WND = 4'd7, C_IMM = 4'd8
  } cls_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, state_nx;
  cls_t       cls, dec_cls;
  logic [2:0] rf, dec_rf;
  logic       dec_legal;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       illegal_q, bus_err_q;

  assign timeout   = !mem_ready && (wait_cnt == TMO);
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign busy      = (state != S_HALT) || !rst_n;
  assign dbg_state = state;

  always_comb begin
    dec_cls   = C_LOAD;
    dec_rf    = 3'd0;
    dec_legal = 1'b1;
    case (opcode)
      4'b0000: dec_cls = C_LOAD;
      4'b0001: dec_cls = C_STORE;
      4'b0010: dec_cls = C_JUMP;
      4'b0100: dec_cls = C_BRANCH;
      4'b1000: begin
        case (fun)
          8'h01: dec_cls = C_MOVE;
          8'h02: begin dec_cls = C_ALU; dec_rf = 3'd1; end
          8'h04: begin dec_cls = C_ALU; dec_rf = 3'd2; end
          8'h08: begin dec_cls = C_ALU; dec_rf = 3'd3; end
          8'h10: begin dec_cls = C_ALU; dec_rf = 3'd4; end
          8'h20: begin dec_cls = C_ALU; dec_rf = 3'd5; end
          8'h40: begin dec_cls = C_CMP; dec_rf = 3'd6; end
          8'h80, 8'h81, 8'h82, 8'h83: dec_cls = C_WND;
          default: dec_legal = 1'b0;
        endcase
      end
      4'b1100: begin dec_cls = C_IMM; dec_rf = 3'd1; end
      4'b1101: begin dec_cls = C_IMM; dec_rf = 3'd2; end
      4'b1110: begin dec_cls = C_IMM; dec_rf = 3'd3; end
      4'b1111: begin dec_cls = C_IMM; dec_rf = 3'd4; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      cls       <= C_LOAD;
      rf        <= 3'd0;
      wait_cnt  <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        cls <= dec_cls;
        rf  <= dec_rf;
        if (!dec_legal) illegal_q <= 1'b1;
      end
      if ((state == S_FETCH || state == S_MEM) && timeout) bus_err_q <= 1'b1;
      // Any state change restarts the wait count, so entry to FETCH/MEM starts at zero.
      if (state_nx != state) wait_cnt <= 8'd0;
      else if (!mem_ready && wait_cnt != 8'hff) wait_cnt <= 8'(wait_cnt + 8'd1);
    end
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwen   = 1'b0;
    ir_wen   = 1'b0;
    pc_wen   = 1'b0;
    pc_sel   = 2'd0;
    resfun   = 3'd0;
    selmem   = 1'b0;
    selimm   = 1'b0;
    seldata  = 1'b0;
    wen      = 1'b0;
    ldwnd    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wen   = 1'b1;
          pc_wen   = 1'b1;
          state_nx = S_DECODE;
        end else if (timeout) begin
          state_nx = S_HALT;
        end
      end
      S_DECODE: state_nx = dec_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: begin selimm = 1'b1; state_nx = S_MEM; end
          C_JUMP: begin pc_wen = 1'b1; pc_sel = 2'd1; state_nx = S_FETCH; end
          C_BRANCH: begin
            if (!zero) begin
              pc_wen = 1'b1;
              pc_sel = 2'd2;
            end
            state_nx = S_FETCH;
          end
          C_MOVE: begin seldata = 1'b1; state_nx = S_WB; end
          C_ALU:  begin resfun = rf; seldata = 1'b1; state_nx = S_WB; end
          C_IMM:  begin resfun = rf; selimm = 1'b1; state_nx = S_WB; end
          C_CMP:  begin resfun = rf; state_nx = S_FETCH; end
          C_WND:  begin ldwnd = 1'b1; state_nx = S_FETCH; end
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        selimm  = 1'b1;
        memwen  = (cls == C_STORE);
        if (mem_ready) state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
        else if (timeout) state_nx = S_HALT;
      end
      S_WB: begin
        // Operand/result muxes stay where EXEC left them while the write lands.
        wen = 1'b1;
        case (cls)
          C_LOAD: begin selmem = 1'b1; selimm = 1'b1; end
          C_MOVE: seldata = 1'b1;
          C_ALU:  begin resfun = rf; seldata = 1'b1; end
          C_IMM:  begin resfun = rf; selimm = 1'b1; end
          default: ;
        endcase
        state_nx = S_FETCH;
      end
      default: state_nx = S_HALT;
    endcase
    // Reset silences every strobe at once, even in the middle of an access.
    if (!rst_n) begin
      mem_req = 1'b0;
      iord    = 1'b0;
      memwen  = 1'b0;
      ir_wen  = 1'b0;
      pc_wen  = 1'b0;
      pc_sel  = 2'd0;
      resfun  = 3'd0;
      selmem  = 1'b0;
      selimm  = 1'b0;
      seldata = 1'b0;
      wen     = 1'b0;
      ldwnd   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors against
// hand-computed expectations, with MEM_TIMEOUT set to 4.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [7:0] fun;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwen, ir_wen, pc_wen;
  logic [1:0] pc_sel;
  logic [2:0] resfun;
  logic       selmem, selimm, seldata, wen, ldwnd, illegal, bus_err, busy;
  logic [2:0] dbg_state;
  logic [17:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [17:0] BUSY  = 18'h1 << 0;
  localparam logic [17:0] BERR  = 18'h1 << 1;
  localparam logic [17:0] ILL   = 18'h1 << 2;
  localparam logic [17:0] LDW   = 18'h1 << 3;
  localparam logic [17:0] WEN   = 18'h1 << 4;
  localparam logic [17:0] SDATA = 18'h1 << 5;
  localparam logic [17:0] SIMM  = 18'h1 << 6;
  localparam logic [17:0] SMEM  = 18'h1 << 7;
  localparam logic [17:0] PSEL1 = 18'h1 << 11;
  localparam logic [17:0] PSEL2 = 18'h2 << 11;
  localparam logic [17:0] PCW   = 18'h1 << 13;
  localparam logic [17:0] IRW   = 18'h1 << 14;
  localparam logic [17:0] MWEN  = 18'h1 << 15;
  localparam logic [17:0] IORD  = 18'h1 << 16;
  localparam logic [17:0] MREQ  = 18'h1 << 17;
  localparam logic [17:0] FETCH_V = MREQ | IRW | PCW | BUSY;
  localparam logic [17:0] MEMW_V  = MREQ | IORD | SIMM | BUSY;

  function automatic logic [17:0] rf(input int n);
    return 18'(n) << 8;
  endfunction

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fun(fun), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwen(memwen),
    .ir_wen(ir_wen), .pc_wen(pc_wen), .pc_sel(pc_sel), .resfun(resfun),
    .selmem(selmem), .selimm(selimm), .seldata(seldata), .wen(wen),
    .ldwnd(ldwnd), .illegal(illegal), .bus_err(bus_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  assign ctl = {mem_req, iord, memwen, ir_wen, pc_wen, pc_sel, resfun,
                selmem, selimm, seldata, wen, ldwnd, illegal, bus_err, busy};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the next rising edge, check at the falling edge.
  task automatic step(input logic [3:0] op, input logic [7:0] fn, input logic z,
                      input logic rdy, input string tag, input logic [17:0] exp);
    @(posedge clk);
    #1;
    opcode    = op;
    fun       = fn;
    zero      = z;
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, ctl, exp);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'd0; fun = 8'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", ctl, BUSY);

    // Reset dropped in the middle of a waiting fetch.
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("fetch_wait", ctl, MREQ | BUSY);
    #2 rst_n = 1'b0;
    #1 chk("reset_midfetch", ctl, BUSY);
    @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1; opcode = 4'b1000; fun = 8'h04;
    @(negedge clk);
    chk("first_fetch", ctl, FETCH_V);

    // ALU fun 0x04
    step(4'b1000, 8'h04, 1'b0, 1'b1, "alu_decode", BUSY);
    step(4'b1000, 8'h04, 1'b0, 1'b1, "alu_exec", rf(2) | SDATA | BUSY);
    step(4'b1000, 8'h04, 1'b0, 1'b1, "alu_wb", rf(2) | SDATA | WEN | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "alu_next_fetch", FETCH_V);

    // Load with three memory wait cycles
    step(4'b0000, 8'h00, 1'b0, 1'b1, "ld_decode", BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "ld_exec", SIMM | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "ld_mem_w1", MEMW_V);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "ld_mem_w2", MEMW_V);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "ld_mem_w3", MEMW_V);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "ld_mem_rdy", MEMW_V);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "ld_wb", SMEM | SIMM | WEN | BUSY);
    step(4'b0001, 8'h00, 1'b0, 1'b1, "ld_next_fetch", FETCH_V);

    // Store, zero-wait
    step(4'b0001, 8'h00, 1'b0, 1'b1, "st_decode", BUSY);
    step(4'b0001, 8'h00, 1'b0, 1'b1, "st_exec", SIMM | BUSY);
    step(4'b0001, 8'h00, 1'b0, 1'b1, "st_mem", MEMW_V | MWEN);
    step(4'b0100, 8'h00, 1'b0, 1'b1, "st_next_fetch", FETCH_V);

    // Branch taken (zero = 0) then not taken (zero = 1)
    step(4'b0100, 8'h00, 1'b0, 1'b1, "br_t_decode", BUSY);
    step(4'b0100, 8'h00, 1'b0, 1'b1, "br_t_exec", PCW | PSEL2 | BUSY);
    step(4'b0100, 8'h00, 1'b1, 1'b1, "br_t_next_fetch", FETCH_V);
    step(4'b0100, 8'h00, 1'b1, 1'b1, "br_n_decode", BUSY);
    step(4'b0100, 8'h00, 1'b1, 1'b1, "br_n_exec", BUSY);
    step(4'b0010, 8'h00, 1'b0, 1'b1, "br_n_next_fetch", FETCH_V);

    // Jump, compare, window load
    step(4'b0010, 8'h00, 1'b0, 1'b1, "jmp_decode", BUSY);
    step(4'b0010, 8'h00, 1'b0, 1'b1, "jmp_exec", PCW | PSEL1 | BUSY);
    step(4'b1000, 8'h40, 1'b0, 1'b1, "jmp_next_fetch", FETCH_V);
    step(4'b1000, 8'h40, 1'b0, 1'b1, "cmp_decode", BUSY);
    step(4'b1000, 8'h40, 1'b0, 1'b1, "cmp_exec", rf(6) | BUSY);
    step(4'b1000, 8'h82, 1'b0, 1'b1, "cmp_next_fetch", FETCH_V);
    step(4'b1000, 8'h82, 1'b0, 1'b1, "wnd_decode", BUSY);
    step(4'b1000, 8'h82, 1'b0, 1'b1, "wnd_exec", LDW | BUSY);
    step(4'b1110, 8'h00, 1'b0, 1'b1, "wnd_next_fetch", FETCH_V);

    // Immediate (opcode 1110 -> resfun 3) and move
    step(4'b1110, 8'h00, 1'b0, 1'b1, "imm_decode", BUSY);
    step(4'b1110, 8'h00, 1'b0, 1'b1, "imm_exec", rf(3) | SIMM | BUSY);
    step(4'b1110, 8'h00, 1'b0, 1'b1, "imm_wb", rf(3) | SIMM | WEN | BUSY);
    step(4'b1000, 8'h01, 1'b0, 1'b1, "imm_next_fetch", FETCH_V);
    step(4'b1000, 8'h01, 1'b0, 1'b1, "mov_decode", BUSY);
    step(4'b1000, 8'h01, 1'b0, 1'b1, "mov_exec", SDATA | BUSY);
    step(4'b1000, 8'h01, 1'b0, 1'b1, "mov_wb", SDATA | WEN | BUSY);

    // Fetch where mem_ready arrives exactly at the timeout cycle: no error
    step(4'b0011, 8'h00, 1'b0, 1'b0, "tmo_edge_c0", MREQ | BUSY);
    step(4'b0011, 8'h00, 1'b0, 1'b0, "tmo_edge_c1", MREQ | BUSY);
    step(4'b0011, 8'h00, 1'b0, 1'b0, "tmo_edge_c2", MREQ | BUSY);
    step(4'b0011, 8'h00, 1'b0, 1'b0, "tmo_edge_c3", MREQ | BUSY);
    step(4'b0011, 8'h00, 1'b0, 1'b1, "tmo_edge_c4", FETCH_V);
    step(4'b0011, 8'h00, 1'b0, 1'b1, "tmo_edge_decode", BUSY);

    // Undefined opcode 0011 halts
    step(4'b0011, 8'h00, 1'b0, 1'b1, "ill_op_halt", ILL);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "ill_op_hold", ILL);

    // Reset clears illegal; then fetch with no ready times out
    @(posedge clk); #1 rst_n = 1'b0; mem_ready = 1'b0;
    #1 chk("reset_clears_ill", ctl, BUSY);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tmo_c0", ctl, MREQ | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "tmo_c1", MREQ | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "tmo_c2", MREQ | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "tmo_c3", MREQ | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "tmo_c4", MREQ | BUSY);
    step(4'b0000, 8'h00, 1'b0, 1'b0, "tmo_halt", BERR);
    step(4'b0000, 8'h00, 1'b0, 1'b1, "tmo_hold", BERR);

    // Undefined fun 0x05 under opcode 1000
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("reset_clears_berr", ctl, BUSY);
    @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1; opcode = 4'b1000; fun = 8'h05;
    @(negedge clk);
    chk("ill_fun_fetch", ctl, FETCH_V);
    step(4'b1000, 8'h05, 1'b0, 1'b1, "ill_fun_decode", BUSY);
    step(4'b1000, 8'h05, 1'b0, 1'b1, "ill_fun_halt", ILL);
    step(4'b1000, 8'h04, 1'b0, 1'b1, "ill_fun_hold", ILL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
